// File: rtl/add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : add_sequencer (with helper FullAdderN)
//  Brief    : Multi-cycle N-bit adder that sequences one W-bit ripple slice
//             per clock and keeps the inter-slice carry in a register.
//             Operands arrive and results leave over valid/ready handshakes.
//             Optional macro ADD_SEQ_SUB_EN adds a Sub input that selects
//             X - Y - CarryIn (CarryIn acts as borrow-in).
//  Revision : 1.0 - initial release
// ============================================================================

// W-bit ripple-carry adder slice
module FullAdderN #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N:0] w_c;

    assign w_c[0] = Cin;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign S[i]     = A[i] ^ B[i] ^ w_c[i];
            assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = w_c[N];

endmodule

module add_sequencer #(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         CarryIn,
`ifdef ADD_SEQ_SUB_EN
    input  logic         Sub,
`endif
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] Sum,
    output logic         CarryOut,
    output logic         Busy
);

    localparam int c_slices = N / W;
    localparam int c_idx_w  = (c_slices > 1) ? $clog2(c_slices) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_slices - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N-1:0]       r_x;
    logic [N-1:0]       r_y;
    logic [N-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_idx_w-1:0] r_idx;

    logic [N-1:0]       w_y_in;
    logic               w_cin;
    logic [W-1:0]       w_slice_sum;
    logic               w_slice_cout;
    logic               w_accept;
    logic               w_last;

    // Subtraction is add of the inverted operand with inverted carry-in,
    // so the same slice serves both operations.
`ifdef ADD_SEQ_SUB_EN
    assign w_y_in = Sub ? ~Y : Y;
    assign w_cin  = CarryIn ^ Sub;
`else
    assign w_y_in = Y;
    assign w_cin  = CarryIn;
`endif

    assign w_accept = (r_state == c_idle) && InValid;
    assign w_last   = (r_idx == c_last_idx);

    FullAdderN #(
        .N (W)
    ) u_slice (
        .A    (r_x[r_idx*W +: W]),
        .B    (r_y[r_idx*W +: W]),
        .Cin  (r_carry),
        .S    (w_slice_sum),
        .Cout (w_slice_cout)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (InValid)  w_state_nxt = c_run;
            c_run:   if (w_last)   w_state_nxt = c_done;
            c_done:  if (OutReady) w_state_nxt = c_idle;
            default:               w_state_nxt = c_idle;
        endcase
    end

    // Handshake/status outputs decoded from state only
    always_comb begin
        InReady  = (r_state == c_idle);
        OutValid = (r_state == c_done);
        Busy     = (r_state != c_idle);
    end

    // Operand capture and slice-by-slice accumulation of the sum
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_x     <= X;
            r_y     <= w_y_in;
            r_carry <= w_cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == c_run) begin
            r_sum[r_idx*W +: W] <= w_slice_sum;
            r_carry             <= w_slice_cout;
            if (w_last) begin
                r_cout <= w_slice_cout;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign Sum      = r_sum;
    assign CarryOut = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sequencer
//  Brief    : Directed self-checking bench for add_sequencer (N=64, W=8).
//             Subtract vectors are compiled in when ADD_SEQ_SUB_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_sequencer;

    localparam int c_n = 64;
    localparam int c_w = 8;
    localparam int c_lat = c_n / c_w;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_n-1:0] x;
    logic [c_n-1:0] y;
    logic           cin;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [c_n-1:0] sum;
    logic           cout;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add_sequencer #(
        .N (c_n),
        .W (c_w)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .X        (x),
        .Y        (y),
        .CarryIn  (cin),
`ifdef ADD_SEQ_SUB_EN
        .Sub      (sub),
`endif
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Sum      (sum),
        .CarryOut (cout),
        .Busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with immediate result acceptance
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s,
                          input logic [63:0] exp_sum, input logic exp_co);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
        x = a; y = b; cin = c; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = '1; y = '1; cin = ~c; sub = ~s;
        chk({tag, ".busy"}, {62'd0, busy, in_ready}, 64'd2);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(c_lat));
        chk({tag, ".sum"}, sum, exp_sum);
        chk({tag, ".cout"}, {63'd0, cout}, {63'd0, exp_co});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        int guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst.inready",  {63'd0, in_ready},  64'd1);
        chk("rst.outvalid", {63'd0, out_valid}, 64'd0);
        chk("rst.busy",     {63'd0, busy},      64'd0);
        chk("rst.sum",      sum,                64'd0);
        chk("rst.cout",     {63'd0, cout},      64'd0);

        // Directed arithmetic vectors
        run_op("msb",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd1, 1'b1);
        run_op("small", 64'd231, 64'd698, 1'b0, 1'b0, 64'd929, 1'b0);
        run_op("dec",   64'd999999999, 64'd1, 1'b0, 1'b0, 64'd1000000000, 1'b0);
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        run_op("ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        run_op("mix",   64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
               64'h1234_5678_9ABC_DF01, 1'b0);

        // Backpressure: result held while new operands are offered
        x = 64'd5; y = 64'd7; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk("bp.reach", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            x = 64'd100 + 64'(i); y = 64'd200; cin = 1'b1;
            in_valid = (i % 2 == 0);
            tick();
            chk("bp.outvalid", {63'd0, out_valid}, 64'd1);
            chk("bp.sum",      sum,                64'd12);
            chk("bp.cout",     {63'd0, cout},      64'd0);
            chk("bp.inready",  {63'd0, in_ready},  64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.release", {62'd0, in_ready, out_valid}, 64'd2);
        tick(); tick();
        chk("bp.noaccept", {62'd0, busy, in_ready}, 64'd1);

        // Reset in the middle of RUN at slice index 3
        x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'h1; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid.busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.inready",  {63'd0, in_ready},  64'd1);
        chk("mid.outvalid", {63'd0, out_valid}, 64'd0);
        chk("mid.sum",      sum,                64'd0);
        run_op("fresh", 64'd40, 64'd2, 1'b0, 1'b0, 64'd42, 1'b0);

`ifdef ADD_SEQ_SUB_EN
        run_op("sub1", 64'd1000, 64'd1, 1'b0, 1'b1, 64'd999, 1'b1);
        run_op("sub2", 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("sub0", 64'd231, 64'd698, 1'b0, 1'b0, 64'd929, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/add_sequencer.md
# add_sequencer

Multi-cycle controller that sequences one narrow W-bit ripple adder slice, built as `FullAdderN` with n = W, across N-bit operands. It accepts operands over a valid/ready handshake and adds one W-bit slice per cycle, keeping the carry in a register between slices. It presents the N-bit sum and final carry over a second valid/ready handshake. It sits between an operand producer and a result consumer, trading latency for adder area.

## Interface
- N, 64, operand/sum width; must be an integer multiple of W
- W, 8, slice width of the instantiated `FullAdderN`; 1 ≤ W ≤ N
- Clock  in  1  sole clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  producer has operands on X, Y, CarryIn
- InReady  out  1  block can accept operands
- X  in  N  operand A
- Y  in  N  operand B
- CarryIn  in  1  carry into bit 0
- OutValid  out  1  Sum/CarryOut hold a completed result
- OutReady  in  1  consumer takes the result
- Sum  out  N  result
- CarryOut  out  1  carry out of bit N-1
- Busy  out  1  high in RUN or DONE

## Operation
- K = N/W slices; slice index register is ceil(log2 K) bits wide, minimum 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - InReady = 1.
  - On an edge with InValid & InReady: latch X and Y into operand registers, load carry register with CarryIn, index = 0, Sum = 0, CarryOut = 0, go to RUN.
- RUN:
  - InReady = 0.
  - Each edge: Sum[idx*W +: W] ← slice sum of X[idx*W +: W], Y[idx*W +: W] and the carry register; carry register ← slice carry-out; idx ← idx + 1.
  - On the edge processing idx = K-1: CarryOut ← slice carry-out, go to DONE; idx wraps to 0.
- DONE:
  - OutValid = 1. Sum and CarryOut are held stable.
  - On an edge with OutReady, go to IDLE.
  - OutValid never drops before that handshake.
- InValid is ignored outside IDLE. X, Y and CarryIn may change freely after the accept edge.
- Arithmetic is modulo 2^N on Sum; the carry out of the top bit appears only on CarryOut.
- Reset has priority over every other event, including mid-RUN or mid-DONE. The operation in flight is discarded.

## Timing
- Values after a reset edge: state IDLE, InReady 1, OutValid 0, Busy 0, Sum 0, CarryOut 0, idx 0, carry register 0.
- Accept on edge E0 → RUN on edges E1..EK → OutValid high after edge EK.
  - Latency is K cycles from accept to OutValid.
  - With N = 64 and W = 8, latency is 8.
- With OutReady held high, OutValid is high for exactly one cycle. The block returns to IDLE, InReady is high the next cycle, and the next accept can occur then.
  - Minimum initiation interval: K+2 cycles.
- If W = N then K = 1: a single RUN cycle.
- Sum bits of slices not yet processed read 0 during RUN. Sum is valid only while OutValid = 1.
- Busy = (state != IDLE). InReady = (state == IDLE).
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration
- ADD_SEQ_SUB_EN, when defined:
  - Adds input `Sub` (1 bit), sampled at the accept edge and held for the operation.
  - When Sub = 1, the latched Y is inverted (~Y) and the initial carry register is CarryIn ^ 1. The result is X − Y − CarryIn, with CarryIn acting as borrow-in.
  - CarryOut = 1 means no borrow.
  - When Sub = 0, behaviour is identical to the build without the macro.
- When undefined: there is no `Sub` port and the block only adds.

## Test plan
- X = 1<<63, Y = 1<<63, CarryIn = 1, N = 64, W = 8 → Sum = 1, CarryOut = 1, OutValid exactly 8 cycles after the accept edge.
- X = 231, Y = 698, CarryIn = 0 → Sum = 929, CarryOut = 0. Then X = 999999999, Y = 1 → Sum = 1000000000, CarryOut = 0.
- X = all-ones, Y = 0, CarryIn = 1 (carry ripples through every slice) → Sum = 0, CarryOut = 1.
- Backpressure and ignored input:
  - Stimulus: OutReady held low 5 cycles in DONE while pulsing InValid with new operands.
  - Response: OutValid stays 1, Sum and CarryOut unchanged, InReady 0.
  - After OutReady = 1: one handshake, IDLE next cycle, the earlier InValid pulses never accepted.
- Reset asserted for one cycle while in RUN at idx = 3 → next cycle IDLE, InReady 1, OutValid 0, Sum 0. A fresh operation then completes correctly.
- With ADD_SEQ_SUB_EN defined:
  - Sub = 1, X = 1000, Y = 1, CarryIn = 0 → Sum = 999, CarryOut = 1.
  - Sub = 1, X = 0, Y = 1 → Sum = all-ones, CarryOut = 0.
